// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: owns the instruction register, sequences
// FETCH/DECODE/EXEC/MEM/WB with imem/dmem handshakes, a stall watchdog and a sticky halt.
module multicycle_control_unit #(
   parameter int WORD_W      = 32,
   parameter int REG_W       = 5,
   parameter int STALL_LIMIT = 0,
   parameter int CNT_W       = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WORD_W-1:0] imemload,
   input  logic              ihit,
   input  logic              dhit,
   input  logic              zero,
   output logic              imemREN,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic              PCWrite,
   output logic [1:0]        JumpSel,
   output logic              RegWr,
   output logic [1:0]        RegDst,
   output logic [1:0]        MemToReg,
   output logic [1:0]        ALUsrc,
   output logic [3:0]        alu_op,
   output logic              ExtOp,
   output logic [REG_W-1:0]  Rs,
   output logic [REG_W-1:0]  Rt,
   output logic [REG_W-1:0]  Rd,
   output logic [15:0]       imm16,
   output logic [2:0]        state_o,
   output logic              halt,
   output logic              timeout_err
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL
   } aluop_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ   = 6'h04,
                          OP_BNE   = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                          OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F,
                          OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_HALT = 6'h3F;
   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21,
                          F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24, F_OR  = 6'h25, F_XOR = 6'h26,
                          F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

   state_t            state, next_state;
   logic [WORD_W-1:0] ir;
   logic [5:0]        opcode, funct;
   logic [CNT_W-1:0]  stall_cnt;
   logic              waiting, wd_expired, err_set;
   aluop_t            dec_alu;
   logic [1:0]        dec_src;
   logic              dec_ext, dec_legal;

   assign opcode  = ir[WORD_W-1 -: 6];
   assign funct   = ir[5:0];
   assign Rs      = ir[21 +: REG_W];
   assign Rt      = ir[16 +: REG_W];
   assign Rd      = ir[11 +: REG_W];
   assign imm16   = ir[15:0];
   assign state_o = state;

   assign waiting    = (state == S_FETCH && !ihit) || (state == S_MEM && !dhit);
   assign wd_expired = (STALL_LIMIT != 0) && (stall_cnt == LIMIT);

   // Instruction-level decode: ALU controls plus legality of opcode/funct.
   always_comb begin
      dec_alu   = ALU_ADD;
      dec_src   = 2'b00;
      dec_ext   = 1'b0;
      dec_legal = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               F_SLL:         begin dec_alu = ALU_SLL; dec_src = 2'b10; end
               F_SRL:         begin dec_alu = ALU_SRL; dec_src = 2'b10; end
               F_JR, F_ADD, F_ADDU: dec_alu = ALU_ADD;
               F_SUB, F_SUBU: dec_alu = ALU_SUB;
               F_AND:         dec_alu = ALU_AND;
               F_OR:          dec_alu = ALU_OR;
               F_XOR:         dec_alu = ALU_XOR;
               F_NOR:         dec_alu = ALU_NOR;
               F_SLT:         dec_alu = ALU_SLT;
               F_SLTU:        dec_alu = ALU_SLTU;
               default:       dec_legal = 1'b0;
            endcase
         end
         OP_J, OP_JAL, OP_HALT, OP_LUI: ;
         OP_BEQ, OP_BNE:          begin dec_alu = ALU_SUB;  dec_ext = 1'b1; end
         OP_ADDIU, OP_LW, OP_SW:  begin dec_alu = ALU_ADD;  dec_src = 2'b01; dec_ext = 1'b1; end
         OP_SLTI:                 begin dec_alu = ALU_SLT;  dec_src = 2'b01; dec_ext = 1'b1; end
         OP_SLTIU:                begin dec_alu = ALU_SLTU; dec_src = 2'b01; dec_ext = 1'b1; end
         OP_ANDI:                 begin dec_alu = ALU_AND;  dec_src = 2'b01; end
         OP_ORI:                  begin dec_alu = ALU_OR;   dec_src = 2'b01; end
         OP_XORI:                 begin dec_alu = ALU_XOR;  dec_src = 2'b01; end
         default:                 dec_legal = 1'b0;
      endcase
   end

   always_comb begin
      // NOTE: every output is defaulted first so no branch leaves one unassigned and infers a latch.
      next_state = state;
      err_set    = 1'b0;
      imemREN    = 1'b0;
      dmemREN    = 1'b0;
      dmemWEN    = 1'b0;
      PCWrite    = 1'b0;
      JumpSel    = 2'b00;
      RegWr      = 1'b0;
      RegDst     = 2'b00;
      MemToReg   = 2'b00;
      ALUsrc     = 2'b00;
      alu_op     = 4'd0;
      ExtOp      = 1'b0;
      halt       = 1'b0;
      case (state)
         S_FETCH: begin
            imemREN = 1'b1;
            if (ihit) begin
               PCWrite    = 1'b1;
               next_state = S_DECODE;
            end else if (wd_expired) begin
               next_state = S_HALT;
               err_set    = 1'b1;
            end
         end
         S_DECODE: begin
            if (!dec_legal) begin
               next_state = S_HALT;
               err_set    = 1'b1;
            end else if (opcode == OP_HALT) begin
               next_state = S_HALT;
            end else if (opcode == OP_J || opcode == OP_JAL) begin
               PCWrite    = 1'b1;
               JumpSel    = 2'b01;
               next_state = S_FETCH;
               if (opcode == OP_JAL) begin
                  RegWr    = 1'b1;
                  RegDst   = 2'b10;
                  MemToReg = 2'b10;
               end
            end else if (opcode == OP_RTYPE && funct == F_JR) begin
               PCWrite    = 1'b1;
               JumpSel    = 2'b10;
               next_state = S_FETCH;
            end else begin
               next_state = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_op = dec_alu;
            ALUsrc = dec_src;
            ExtOp  = dec_ext;
            case (opcode)
               OP_BEQ:       begin PCWrite = zero;  JumpSel = 2'b11; next_state = S_FETCH; end
               OP_BNE:       begin PCWrite = !zero; JumpSel = 2'b11; next_state = S_FETCH; end
               OP_LW, OP_SW: next_state = S_MEM;
               default:      next_state = S_WB;
            endcase
         end
         S_MEM: begin
            // Only LW and SW reach MEM, so anything that is not LW is a store.
            dmemREN = (opcode == OP_LW);
            dmemWEN = (opcode != OP_LW);
            if (dhit) begin
               next_state = (opcode == OP_LW) ? S_WB : S_FETCH;
            end else if (wd_expired) begin
               next_state = S_HALT;
               err_set    = 1'b1;
            end
         end
         S_WB: begin
            RegWr      = 1'b1;
            RegDst     = (opcode == OP_RTYPE) ? 2'b01 : 2'b00;
            MemToReg   = (opcode == OP_LW) ? 2'b01 : ((opcode == OP_LUI) ? 2'b11 : 2'b00);
            next_state = S_FETCH;
         end
         S_HALT:  halt = 1'b1;
         default: next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= S_FETCH;
         ir          <= '0;
         stall_cnt   <= '0;
         timeout_err <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state <= next_state;
         if (state == S_FETCH && ihit) ir <= imemload;
         if (next_state != state)
            stall_cnt <= '0;
         else if (waiting && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (err_set) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed and random instructions against an instruction-level
// model of the expected per-cycle control outputs.
module tb_multicycle_control_unit;
   localparam int LIM = 4;

   localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
                          S_WB = 3'd4, S_HALT = 3'd5;
   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4,
                          A_NOR = 4'd5, A_SLT = 4'd6, A_SLTU = 4'd7, A_SLL = 4'd8, A_SRL = 4'd9;

   typedef enum logic [3:0] {K_R, K_JR, K_J, K_JAL, K_BEQ, K_BNE, K_LW, K_SW, K_IMM, K_LUI,
                             K_HALT, K_ILL} kind_t;
   typedef struct packed { kind_t k; logic [3:0] alu; logic [1:0] src; logic ext; } cls_t;
   typedef struct packed {
      logic [2:0] st; logic imem, dren, dwen, pcw; logic [1:0] js; logic rw;
      logic [1:0] rd, m2r, src; logic [3:0] alu; logic ext, halt, terr;
   } obs_t;

   logic        CLK = 1'b0, RST = 1'b1, ihit = 1'b0, dhit = 1'b0, zero = 1'b0;
   logic [31:0] imemload = '0;
   logic        imemREN, dmemREN, dmemWEN, PCWrite, RegWr, ExtOp, halt, timeout_err;
   logic [1:0]  JumpSel, RegDst, MemToReg, ALUsrc;
   logic [3:0]  alu_op;
   logic [4:0]  Rs, Rt, Rd;
   logic [15:0] imm16;
   logic [2:0]  state_o;
   obs_t        obs;
   int          total = 0, bad = 0;
   bit          halted;

   always #5 CLK = ~CLK;

   multicycle_control_unit #(.WORD_W(32), .REG_W(5), .STALL_LIMIT(LIM), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .imemload(imemload), .ihit(ihit), .dhit(dhit), .zero(zero),
      .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .PCWrite(PCWrite),
      .JumpSel(JumpSel), .RegWr(RegWr), .RegDst(RegDst), .MemToReg(MemToReg), .ALUsrc(ALUsrc),
      .alu_op(alu_op), .ExtOp(ExtOp), .Rs(Rs), .Rt(Rt), .Rd(Rd), .imm16(imm16),
      .state_o(state_o), .halt(halt), .timeout_err(timeout_err)
   );

   assign obs = {state_o, imemREN, dmemREN, dmemWEN, PCWrite, JumpSel, RegWr, RegDst, MemToReg,
                 ALUsrc, alu_op, ExtOp, halt, timeout_err};

   function automatic obs_t base(input logic [2:0] st);
      obs_t e;
      e    = '0;
      e.st = st;
      return e;
   endfunction

   function automatic cls_t classify(input logic [31:0] iw);
      cls_t c;
      c = '{k: K_ILL, alu: A_ADD, src: 2'b00, ext: 1'b0};
      case (iw[31:26])
         6'h00: begin
            c.k = K_R;
            case (iw[5:0])
               6'h00: begin c.alu = A_SLL; c.src = 2'b10; end
               6'h02: begin c.alu = A_SRL; c.src = 2'b10; end
               6'h08: c.k = K_JR;
               6'h20, 6'h21: c.alu = A_ADD;
               6'h22, 6'h23: c.alu = A_SUB;
               6'h24: c.alu = A_AND;
               6'h25: c.alu = A_OR;
               6'h26: c.alu = A_XOR;
               6'h27: c.alu = A_NOR;
               6'h2A: c.alu = A_SLT;
               6'h2B: c.alu = A_SLTU;
               default: c.k = K_ILL;
            endcase
         end
         6'h02: c.k = K_J;
         6'h03: c.k = K_JAL;
         6'h04: begin c.k = K_BEQ; c.alu = A_SUB; c.ext = 1'b1; end
         6'h05: begin c.k = K_BNE; c.alu = A_SUB; c.ext = 1'b1; end
         6'h09: begin c.k = K_IMM; c.alu = A_ADD;  c.src = 2'b01; c.ext = 1'b1; end
         6'h0A: begin c.k = K_IMM; c.alu = A_SLT;  c.src = 2'b01; c.ext = 1'b1; end
         6'h0B: begin c.k = K_IMM; c.alu = A_SLTU; c.src = 2'b01; c.ext = 1'b1; end
         6'h0C: begin c.k = K_IMM; c.alu = A_AND;  c.src = 2'b01; end
         6'h0D: begin c.k = K_IMM; c.alu = A_OR;   c.src = 2'b01; end
         6'h0E: begin c.k = K_IMM; c.alu = A_XOR;  c.src = 2'b01; end
         6'h0F: c.k = K_LUI;
         6'h23: begin c.k = K_LW; c.alu = A_ADD; c.src = 2'b01; c.ext = 1'b1; end
         6'h2B: begin c.k = K_SW; c.alu = A_ADD; c.src = 2'b01; c.ext = 1'b1; end
         6'h3F: c.k = K_HALT;
         default: c.k = K_ILL;
      endcase
      return c;
   endfunction

   task automatic chk(input obs_t e, input string tag);
      total++;
      assert (obs === e) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
   endtask

   // One clock: drive inputs just after the falling edge, sample before the rising edge.
   task automatic cyc(input logic ih, input logic dh, input logic z, input logic [31:0] iw,
                      input obs_t e, input string tag);
      @(negedge CLK);
      ihit = ih; dhit = dh; zero = z; imemload = iw;
      #1;
      chk(e, tag);
   endtask

   task automatic apply_reset();
      obs_t e;
      @(negedge CLK);
      RST = 1'b1; ihit = 1'b0; dhit = 1'b0;
      #1;
      e = base(S_FETCH); e.imem = 1'b1;
      chk(e, "reset_outputs");
      total++;
      assert ({Rs, Rt, Rd, imm16} === 31'd0) else begin
         bad++;
         $error("FAIL reset_fields: observed=%h expected=0", {Rs, Rt, Rd, imm16});
      end
      @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   task automatic run_instr(input logic [31:0] iw, input int fst, input int mst, input logic z,
                            output bit hlt);
      cls_t c;
      obs_t e;
      c   = classify(iw);
      hlt = 1'b0;
      e = base(S_FETCH); e.imem = 1'b1;
      for (int i = 0; i < fst && i <= LIM; i++) cyc(1'b0, 1'b0, z, iw, e, "fetch_wait");
      if (fst > LIM) begin
         e = base(S_HALT); e.halt = 1'b1; e.terr = 1'b1;
         cyc(1'b0, 1'b0, z, iw, e, "fetch_timeout");
         hlt = 1'b1;
         return;
      end
      e.pcw = 1'b1;
      cyc(1'b1, 1'b0, z, iw, e, "fetch_hit");

      e = base(S_DECODE);
      case (c.k)
         K_J:   begin e.pcw = 1'b1; e.js = 2'b01; end
         K_JAL: begin e.pcw = 1'b1; e.js = 2'b01; e.rw = 1'b1; e.rd = 2'b10; e.m2r = 2'b10; end
         K_JR:  begin e.pcw = 1'b1; e.js = 2'b10; end
         default: ;
      endcase
      cyc(1'b0, 1'b0, z, iw, e, "decode");
      total++;
      assert ({Rs, Rt, Rd, imm16} === {iw[25:21], iw[20:16], iw[15:11], iw[15:0]}) else begin
         bad++;
         $error("FAIL ir_fields: observed=%h expected=%h", {Rs, Rt, Rd, imm16},
                {iw[25:21], iw[20:16], iw[15:11], iw[15:0]});
      end
      if (c.k inside {K_J, K_JAL, K_JR}) return;
      if (c.k == K_HALT || c.k == K_ILL) begin
         e = base(S_HALT); e.halt = 1'b1; e.terr = (c.k == K_ILL);
         cyc(1'b0, 1'b0, z, iw, e, "halt_entry");
         cyc(1'b1, 1'b1, z, iw, e, "halt_sticky");
         hlt = 1'b1;
         return;
      end

      e = base(S_EXEC); e.alu = c.alu; e.src = c.src; e.ext = c.ext;
      if (c.k == K_BEQ) begin e.pcw = z;  e.js = 2'b11; end
      if (c.k == K_BNE) begin e.pcw = !z; e.js = 2'b11; end
      cyc(1'b0, 1'b0, z, iw, e, "exec");
      if (c.k == K_BEQ || c.k == K_BNE) return;

      if (c.k == K_LW || c.k == K_SW) begin
         e = base(S_MEM); e.dren = (c.k == K_LW); e.dwen = (c.k == K_SW);
         for (int i = 0; i < mst && i <= LIM; i++) cyc(1'b0, 1'b0, z, iw, e, "mem_wait");
         if (mst > LIM) begin
            e = base(S_HALT); e.halt = 1'b1; e.terr = 1'b1;
            cyc(1'b0, 1'b0, z, iw, e, "mem_timeout");
            hlt = 1'b1;
            return;
         end
         cyc(1'b0, 1'b1, z, iw, e, "mem_hit");
         if (c.k == K_SW) return;
      end

      e = base(S_WB); e.rw = 1'b1;
      e.rd  = (c.k == K_R) ? 2'b01 : 2'b00;
      e.m2r = (c.k == K_LW) ? 2'b01 : ((c.k == K_LUI) ? 2'b11 : 2'b00);
      cyc(1'b0, 1'b0, z, iw, e, "writeback");
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [5:0]  ops [16];
      logic [5:0]  fns [14];
      ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
              6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
      fns = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
              6'h2A, 6'h2B, 6'h3E};
      w = $urandom;
      if ($urandom_range(0, 19) == 0) w[31:26] = 6'h11;
      else w[31:26] = ops[$urandom_range(0, 15)];
      if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 13)];
      return w;
   endfunction

   function automatic int rand_stall();
      return ($urandom_range(0, 11) == 0) ? 5 + int'($urandom_range(0, 2)) : int'($urandom_range(0, LIM));
   endfunction

   initial begin
      apply_reset();

      // ADDU r3,r1,r2 then LW with three stalled data cycles.
      run_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 0, 0, 1'b0, halted);
      run_instr({6'h23, 5'd4, 5'd5, 16'h0010}, 0, 3, 1'b0, halted);
      // Branches with zero=1, then zero=0.
      run_instr({6'h04, 5'd1, 5'd2, 16'hFFFC}, 0, 0, 1'b1, halted);
      run_instr({6'h05, 5'd1, 5'd2, 16'h0008}, 0, 0, 1'b1, halted);
      run_instr({6'h05, 5'd1, 5'd2, 16'h0008}, 1, 0, 1'b0, halted);
      // JAL, JR, LUI, SW, ORI.
      run_instr({6'h03, 26'h0000123}, 0, 0, 1'b0, halted);
      run_instr({6'h00, 5'd31, 15'd0, 6'h08}, 2, 0, 1'b0, halted);
      run_instr({6'h0F, 5'd0, 5'd7, 16'hBEEF}, 0, 0, 1'b0, halted);
      run_instr({6'h2B, 5'd2, 5'd9, 16'h8000}, 0, 4, 1'b0, halted);
      run_instr({6'h0D, 5'd2, 5'd9, 16'h00FF}, 0, 0, 1'b0, halted);

      // Watchdog: ihit stuck low expires; ihit arriving on the last allowed cycle wins.
      run_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 10, 0, 1'b0, halted);
      apply_reset();
      run_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 4, 0, 1'b0, halted);
      // Data-side watchdog expiry.
      run_instr({6'h23, 5'd4, 5'd5, 16'h0010}, 0, 5, 1'b0, halted);
      apply_reset();

      // HALT opcode, reset while halted; then an illegal opcode and an illegal funct.
      run_instr({6'h3F, 26'd0}, 0, 0, 1'b0, halted);
      apply_reset();
      run_instr({6'h11, 26'h155}, 0, 0, 1'b0, halted);
      apply_reset();
      run_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3E}, 0, 0, 1'b0, halted);
      apply_reset();

      // Reset in the middle of a load, then a normal instruction.
      cyc(1'b1, 1'b0, 1'b0, {6'h23, 5'd4, 5'd5, 16'h0010}, '{st: S_FETCH, imem: 1'b1, pcw: 1'b1, default: '0}, "mid_fetch");
      cyc(1'b0, 1'b0, 1'b0, 32'd0, base(S_DECODE), "mid_decode");
      apply_reset();
      run_instr({6'h00, 5'd6, 5'd7, 5'd8, 5'd2, 6'h00}, 0, 0, 1'b0, halted);

      for (int n = 0; n < 150; n++) begin
         run_instr(rand_instr(), rand_stall(), rand_stall(), 1'($urandom_range(0, 1)), halted);
         if (halted) apply_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
